// File: rtl/psum_deskew_fifo.sv
// Deskews the diagonal psum wavefront of a systolic array into aligned rows
// and buffers them in a show-ahead FIFO. Optional ReLU at write: DESKEW_RELU_EN.
module psum_deskew_fifo #(
    parameter int ARRAY_COL  = 12,
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic [ARRAY_COL*ACC_WIDTH-1:0]       in_psum_vec,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ARRAY_COL*ACC_WIDTH-1:0]       out_psum_vec,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
    output logic                                 overflow,
    input  logic                                 clr_ovf
);

    localparam int RW = ARRAY_COL * ACC_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                 w_push_req;
    logic [ACC_WIDTH-1:0] w_lane [ARRAY_COL];
    logic [RW-1:0]        w_wr_row;

    // Valid travels with the slowest lane so the push lines up with lane 0.
    generate
        if (ARRAY_COL == 1) begin : g_no_vpipe
            assign w_push_req = in_valid;
        end else begin : g_vpipe
            logic [ARRAY_COL-2:0] r_vpipe;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe[0] <= in_valid;
                    for (int k = 1; k < ARRAY_COL - 1; k++) begin
                        r_vpipe[k] <= r_vpipe[k-1];
                    end
                end
            end
            assign w_push_req = r_vpipe[ARRAY_COL-2];
        end
    endgenerate

    // Lane c arrives c cycles late, so it gets ARRAY_COL-1-c stages of delay.
    generate
        for (genvar c = 0; c < ARRAY_COL; c++) begin : g_lane
            localparam int LANE_DLY = ARRAY_COL - 1 - c;
            if (LANE_DLY == 0) begin : g_pass
                assign w_lane[c] = in_psum_vec[c*ACC_WIDTH +: ACC_WIDTH];
            end else begin : g_dly
                logic [ACC_WIDTH-1:0] r_pipe [LANE_DLY];
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int k = 0; k < LANE_DLY; k++) begin
                            r_pipe[k] <= '0;
                        end
                    end else begin
                        r_pipe[0] <= in_psum_vec[c*ACC_WIDTH +: ACC_WIDTH];
                        for (int k = 1; k < LANE_DLY; k++) begin
                            r_pipe[k] <= r_pipe[k-1];
                        end
                    end
                end
                assign w_lane[c] = r_pipe[LANE_DLY-1];
            end
        end
    endgenerate

    always_comb begin
        w_wr_row = '0;
        for (int c = 0; c < ARRAY_COL; c++) begin
`ifdef DESKEW_RELU_EN
            if (w_lane[c][ACC_WIDTH-1]) begin
                w_wr_row[c*ACC_WIDTH +: ACC_WIDTH] = '0;
            end else begin
                w_wr_row[c*ACC_WIDTH +: ACC_WIDTH] = w_lane[c];
            end
`else
            w_wr_row[c*ACC_WIDTH +: ACC_WIDTH] = w_lane[c];
`endif
        end
    end

    logic [RW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          w_full;
    logic          w_do_pop;
    logic          w_do_push;
    logic          w_drop;

    // A pop on the same edge frees the slot, so a push into a full FIFO still fits.
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_do_pop  = out_valid && out_ready;
    assign w_do_push = w_push_req && (!w_full || w_do_pop);
    assign w_drop    = w_push_req && w_full && !w_do_pop;

    // Storage is not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= w_wr_row;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop outranks a simultaneous clear so no lost row goes unreported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign out_valid    = (r_count != '0);
    assign out_psum_vec = out_valid ? r_mem[r_rptr] : '0;
    assign fifo_count   = r_count;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_psum_deskew_fifo.sv
// Scoreboard bench for psum_deskew_fifo: a skewed feeder drives tokens and an
// occupancy model predicts every row, count and overflow value cycle by cycle.
module tb_psum_deskew_fifo;

    localparam int ARRAY_COL  = 12;
    localparam int ACC_WIDTH  = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int RW         = ARRAY_COL * ACC_WIDTH;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [RW-1:0] in_psum_vec;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_psum_vec;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          clr_ovf;

    psum_deskew_fifo #(
        .ARRAY_COL (ARRAY_COL),
        .ACC_WIDTH (ACC_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_psum_vec (in_psum_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_psum_vec(out_psum_vec),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            arr;
        logic [RW-1:0] row;
    } pend_t;

    pend_t         pendQ[$];
    logic [RW-1:0] modelQ[$];
    logic [RW-1:0] hist [ARRAY_COL];
    logic          modelOvf;
    int            cyc;
    int            cmpCount = 0;
    int            errCount = 0;

    task automatic checkOutput(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        cmpCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] mkRow(input int base);
        logic [RW-1:0] r;
        r = '0;
        for (int c = 0; c < ARRAY_COL; c++) begin
            r[c*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(base + c);
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] expRow(input logic [RW-1:0] r);
        logic [RW-1:0] e;
        e = r;
`ifdef DESKEW_RELU_EN
        for (int c = 0; c < ARRAY_COL; c++) begin
            if (r[c*ACC_WIDTH + ACC_WIDTH - 1]) begin
                e[c*ACC_WIDTH +: ACC_WIDTH] = '0;
            end
        end
`endif
        return e;
    endfunction

    task automatic resetModel();
        pendQ.delete();
        modelQ.delete();
        for (int k = 0; k < ARRAY_COL; k++) begin
            hist[k] = '0;
        end
        modelOvf = 1'b0;
        cyc = 0;
    endtask

    task automatic checkModel();
        logic          expValid;
        logic [RW-1:0] expData;
        expValid = (modelQ.size() > 0);
        expData  = expValid ? modelQ[0] : '0;
        checkOutput("count", RW'(fifo_count), RW'(modelQ.size()));
        checkOutput("valid", RW'(out_valid), RW'(expValid));
        checkOutput("data", out_psum_vec, expData);
        checkOutput("ovf", RW'(overflow), RW'(modelOvf));
    endtask

    // One clock: feed the skewed wavefront, advance the model, compare after the edge.
    task automatic applyStimulus(input logic v, input logic [RW-1:0] row, input logic rdy, input logic clr);
        logic          popNow;
        logic          dropNow;
        logic [RW-1:0] vec;
        pend_t         p;
        popNow = rdy && (modelQ.size() > 0);
        for (int k = ARRAY_COL - 1; k > 0; k--) begin
            hist[k] = hist[k-1];
        end
        hist[0] = v ? row : '0;
        vec = '0;
        for (int c = 0; c < ARRAY_COL; c++) begin
            vec[c*ACC_WIDTH +: ACC_WIDTH] = hist[c][c*ACC_WIDTH +: ACC_WIDTH];
        end
        in_valid    = v;
        in_psum_vec = vec;
        out_ready   = rdy;
        clr_ovf     = clr;
        if (v) begin
            p.arr = cyc + ARRAY_COL - 1;
            p.row = expRow(row);
            pendQ.push_back(p);
        end
        @(posedge clk);
        #1;
        if (popNow) begin
            void'(modelQ.pop_front());
        end
        dropNow = 1'b0;
        if (pendQ.size() > 0 && pendQ[0].arr == cyc) begin
            p = pendQ.pop_front();
            if (modelQ.size() < FIFO_DEPTH) begin
                modelQ.push_back(p.row);
            end else begin
                dropNow  = 1'b1;
                modelOvf = 1'b1;
            end
        end
        if (clr && !dropNow) begin
            modelOvf = 1'b0;
        end
        cyc++;
        checkModel();
    endtask

    initial begin
        logic [RW-1:0] actRow;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_psum_vec = '0;
        out_ready   = 1'b0;
        clr_ovf     = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", RW'(out_valid), '0);
        checkOutput("rst_data", out_psum_vec, '0);
        checkOutput("rst_count", RW'(fifo_count), '0);
        checkOutput("rst_ovf", RW'(overflow), '0);
        rst = 1'b0;

        // Single token driven on edge 10, held until well after it lands.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(i == 10, mkRow(100), 1'b0, 1'b0);
        end
        checkOutput("single_count", RW'(fifo_count), RW'(1));
        checkOutput("single_data", out_psum_vec, mkRow(100));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end

        // Back-to-back stream with the consumer always ready.
        for (int t = 0; t < 45; t++) begin
            applyStimulus(t < 32, mkRow(1000 * t), 1'b1, 1'b0);
        end

        // Negative lanes: -5 on odd lanes.
        actRow = mkRow(7);
        for (int c = 1; c < ARRAY_COL; c += 2) begin
            actRow[c*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(-5);
        end
        for (int i = 0; i < 14; i++) begin
            applyStimulus(i == 0, actRow, 1'b0, 1'b0);
        end
`ifdef DESKEW_RELU_EN
        checkOutput("act_lane1", RW'(out_psum_vec[ACC_WIDTH +: ACC_WIDTH]), RW'(0));
`else
        checkOutput("act_lane1", RW'(out_psum_vec[ACC_WIDTH +: ACC_WIDTH]), RW'(32'hFFFF_FFFB));
`endif
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Overflow: ten tokens into an eight-deep FIFO that never drains.
        for (int t = 0; t < 24; t++) begin
            applyStimulus(t < 10, mkRow(200000 + 1000 * t), 1'b0, 1'b0);
        end
        checkOutput("ovf_count", RW'(fifo_count), RW'(FIFO_DEPTH));
        checkOutput("ovf_flag", RW'(overflow), RW'(1));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("ovf_cleared", RW'(overflow), RW'(0));

        // Clear pulse lands on the very edge of a drop: the flag must stay set.
        for (int i = 0; i < 21; i++) begin
            applyStimulus(i < 9, mkRow(400000 + 1000 * i), 1'b0, i == 19);
        end
        checkOutput("setwins_flag", RW'(overflow), RW'(1));
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Full FIFO: push and pop on the same edge.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i == 0, mkRow(500000), 1'b0 || (i == 11), 1'b0);
        end
        checkOutput("fullpp_count", RW'(fifo_count), RW'(FIFO_DEPTH));
        checkOutput("fullpp_ovf", RW'(overflow), RW'(0));
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end

        // Reset mid-stream with rows stored and more in flight.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(i < 12, mkRow(700000 + 1000 * i), 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", RW'(out_valid), '0);
        checkOutput("midrst_data", out_psum_vec, '0);
        checkOutput("midrst_count", RW'(fifo_count), '0);
        checkOutput("midrst_ovf", RW'(overflow), '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
        end
        checkOutput("postrst_count", RW'(fifo_count), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
